// File: rtl/mem_port_arbiter4.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter4
//
// Round-robin arbiter that shares one single-ported resource (the unified
// memory port) among four pipeline requesters. The registered select drives
// the 4:1 mux in front of the port; the per-requester stall freezes the
// IF/MEM stages that are waiting on the structural hazard. A bounded hold
// counter lets a waiting requester preempt an owner that has kept the port
// for MAX_HOLD consecutive cycles.
//
// Parameters
//   MAX_HOLD : owner cycles before preemption when others wait (0 = never)
//   CNT_W    : hold counter width, 2**CNT_W must exceed MAX_HOLD
//
// Ports
//   clk   in   1  rising-edge clock
//   rst   in   1  asynchronous active-high reset
//   req   in   4  level request per requester, held until served
//   gnt   out  4  registered one-hot grant, zero when idle
//   sel   out  2  registered mux select = index of the granted requester
//   busy  out  1  registered, high while any grant is active
//   stall out  4  combinational req & ~gnt
// -----------------------------------------------------------------------------
module mem_port_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic [3:0] stall
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Hold count at which a waiting requester takes the port away.
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic             PREEMPT_EN = (MAX_HOLD != 0);

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             busy_q, busy_d;

    logic [3:0]       others;
    logic [1:0]       idle_pick;
    logic [1:0]       handoff_pick;

    // First set bit of r when scanning start, start+1, ... modulo 4.
    // Scanning from the far end backwards lets the nearest hit win last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    // Next-state and next-output logic. The owner index is always the
    // registered select, so a hand-off searches from owner+1; the current
    // owner is masked out so it can never re-win its own hand-off.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        busy_d     = busy_q;

        others       = req & ~gnt_q;
        idle_pick    = rr_pick(req, ptr_q);
        handoff_pick = rr_pick(others, sel_q + 2'd1);

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = BUSY;
                    gnt_d      = 4'(1) << idle_pick;
                    sel_d      = idle_pick;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                    ptr_d      = idle_pick + 2'd1;
                end
            end

            BUSY: begin
                if (!req[sel_q]) begin
                    // Owner released: hand straight over without an idle bubble.
                    if (|others) begin
                        gnt_d      = 4'(1) << handoff_pick;
                        sel_d      = handoff_pick;
                        hold_cnt_d = '0;
                        ptr_d      = handoff_pick + 2'd1;
                    end else begin
                        state_d    = IDLE;
                        gnt_d      = 4'b0000;
                        busy_d     = 1'b0;
                        hold_cnt_d = '0;
                    end
                end else if (PREEMPT_EN && (hold_cnt_q == HOLD_LAST) && (|others)) begin
                    // Owner keeps its request and simply stalls until its turn.
                    gnt_d      = 4'(1) << handoff_pick;
                    sel_d      = handoff_pick;
                    hold_cnt_d = '0;
                    ptr_d      = handoff_pick + 2'd1;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            gnt_q      <= 4'b0000;
            sel_q      <= 2'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign busy  = busy_q;
    assign stall = req & ~gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter4.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter4
//
// Directed bench for the four-way memory port arbiter. Inputs change and
// outputs are observed on the falling clock edge, half a period away from
// the rising edge where the arbiter decides.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] stall;

    int compares;
    int mismatches;

    mem_port_arbiter4 #(
        .MAX_HOLD(8),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt),
        .sel(sel),
        .busy(busy),
        .stall(stall)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Puts the arbiter back to its reset state with no requests pending.
    task automatic do_reset();
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset with every requester asking, then requester 0 wins first.
    task automatic test_reset();
        @(negedge clk);
        req = 4'b1111;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compares++;
        if (gnt !== 4'b0000) begin
            mismatches++;
            $display("[TB] FAIL reset_gnt: got %b want 0000", gnt);
        end
        compares++;
        if (sel !== 2'd0) begin
            mismatches++;
            $display("[TB] FAIL reset_sel: got %0d want 0", sel);
        end
        compares++;
        if (busy !== 1'b0) begin
            mismatches++;
            $display("[TB] FAIL reset_busy: got %b want 0", busy);
        end
        compares++;
        if (stall !== 4'b1111) begin
            mismatches++;
            $display("[TB] FAIL reset_stall: got %b want 1111", stall);
        end
        rst = 1'b0;
        @(negedge clk);
        compares++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || busy !== 1'b1) begin
            mismatches++;
            $display("[TB] FAIL reset_first_grant: got gnt=%b sel=%0d busy=%b want gnt=0001 sel=0 busy=1", gnt, sel, busy);
        end
        compares++;
        if (stall !== 4'b1110) begin
            mismatches++;
            $display("[TB] FAIL reset_first_stall: got %b want 1110", stall);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    // Lone request from idle: one cycle latency, release goes idle, sel held.
    task automatic test_single();
        do_reset();
        req = 4'b0100;
        #1;
        compares++;
        if (gnt !== 4'b0000 || stall !== 4'b0100) begin
            mismatches++;
            $display("[TB] FAIL single_pre_edge: got gnt=%b stall=%b want gnt=0000 stall=0100", gnt, stall);
        end
        @(negedge clk);
        compares++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1 || stall !== 4'b0000) begin
            mismatches++;
            $display("[TB] FAIL single_grant: got gnt=%b sel=%0d busy=%b stall=%b want 0100/2/1/0000", gnt, sel, busy, stall);
        end
        req = 4'b0000;
        @(negedge clk);
        compares++;
        if (gnt !== 4'b0000 || sel !== 2'd2 || busy !== 1'b0) begin
            mismatches++;
            $display("[TB] FAIL single_release: got gnt=%b sel=%0d busy=%b want 0000/2/0", gnt, sel, busy);
        end
    endtask

    // All four asking; each owner keeps the port two cycles then drops for
    // one cycle. Grants must rotate 0,1,2,3,0 with no idle cycle between.
    task automatic test_back_to_back();
        logic [1:0] order [5];
        logic [3:0] want;
        order[0] = 2'd0;
        order[1] = 2'd1;
        order[2] = 2'd2;
        order[3] = 2'd3;
        order[4] = 2'd0;
        do_reset();
        req = 4'b1111;
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            want = 4'b0001 << order[n];
            compares++;
            if (gnt !== want || sel !== order[n] || busy !== 1'b1) begin
                mismatches++;
                $display("[TB] FAIL b2b_grant%0d_first: got gnt=%b sel=%0d busy=%b want gnt=%b sel=%0d busy=1", n, gnt, sel, busy, want, order[n]);
            end
            if (n > 0) begin
                req[order[n-1]] = 1'b1;
            end
            @(negedge clk);
            compares++;
            if (gnt !== want) begin
                mismatches++;
                $display("[TB] FAIL b2b_grant%0d_second: got %b want %b", n, gnt, want);
            end
            req[order[n]] = 1'b0;
            @(negedge clk);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    // Requester 1 holds, requester 3 joins; 1 is preempted after 8 cycles.
    task automatic test_preempt();
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        for (int c = 1; c <= 8; c++) begin
            compares++;
            if (gnt !== 4'b0010) begin
                mismatches++;
                $display("[TB] FAIL preempt_hold_c%0d: got gnt=%b want 0010", c, gnt);
            end
            if (c >= 3) begin
                compares++;
                if (stall !== 4'b1000) begin
                    mismatches++;
                    $display("[TB] FAIL preempt_wait_stall_c%0d: got %b want 1000", c, stall);
                end
            end
            if (c == 2) begin
                req[3] = 1'b1;
            end
            @(negedge clk);
        end
        compares++;
        if (gnt !== 4'b1000 || sel !== 2'd3 || stall !== 4'b0010) begin
            mismatches++;
            $display("[TB] FAIL preempt_switch: got gnt=%b sel=%0d stall=%b want 1000/3/0010", gnt, sel, stall);
        end
        req[3] = 1'b0;
        @(negedge clk);
        compares++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin
            mismatches++;
            $display("[TB] FAIL preempt_return: got gnt=%b sel=%0d want 0010/1", gnt, sel);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    // Sole requester is never preempted, however long it holds.
    task automatic test_no_preempt();
        int bad;
        bad = 0;
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        for (int c = 0; c < 30; c++) begin
            if (gnt !== 4'b0100) begin
                bad++;
            end
            @(negedge clk);
        end
        compares++;
        if (bad !== 0) begin
            mismatches++;
            $display("[TB] FAIL sole_hold: got %0d cycles without gnt=0100, want 0 (last gnt=%b)", bad, gnt);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    // Reset mid-grant clears outputs without a clock edge; pointer restarts.
    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        compares++;
        if (gnt !== 4'b0010) begin
            mismatches++;
            $display("[TB] FAIL midrst_setup: got gnt=%b want 0010", gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        compares++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0) begin
            mismatches++;
            $display("[TB] FAIL midrst_async: got gnt=%b busy=%b sel=%0d want 0000/0/0", gnt, busy, sel);
        end
        @(negedge clk);
        req = 4'b1010;
        rst = 1'b0;
        @(negedge clk);
        compares++;
        if (gnt !== 4'b0010 || sel !== 2'd1 || stall !== 4'b1000) begin
            mismatches++;
            $display("[TB] FAIL midrst_after: got gnt=%b sel=%0d stall=%b want 0010/1/1000", gnt, sel, stall);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        compares   = 0;
        mismatches = 0;
        rst        = 1'b1;
        req        = 4'b0000;
        test_reset();
        test_single();
        test_back_to_back();
        test_preempt();
        test_no_preempt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

    // Guard against a stuck simulation.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
